// File: rtl/mem_pkg.sv
// Shared types and defaults for the CPU-side memory controller.
package mem_pkg;

  localparam int unsigned AddrW      = 8;
  localparam int unsigned WbDepthDef = 4;
  localparam int unsigned ReadLatDef = 1;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StRdIssue,
    StRdWait
  } mem_state_e;

  // One posted store: target address and the stored byte.
  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [7:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wr_buf.sv
// Posted-write FIFO: circular storage of {addr, byte} entries.
// With MEM_CTRL_WB_FWD_EN defined it also offers a youngest-match lookup port.
module wr_buf
  import mem_pkg::*;
#(
  parameter int unsigned Depth = WbDepthDef
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef MEM_CTRL_WB_FWD_EN
  ,
  input  logic [AddrW-1:0]         lookup_addr,
  output logic                     lookup_hit,
  output logic [7:0]               lookup_data
`endif
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t           mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                do_push, do_pop;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally (Depth is a power of two).
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

`ifdef MEM_CTRL_WB_FWD_EN
  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (mem_q[idx].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_q[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// CPU memory-port controller: posted-write buffer in front of a 16-bit synchronous RAM,
// with a req/ready handshake for reads. Optional store-to-load forwarding from the buffer is
// enabled by defining MEM_CTRL_WB_FWD_EN; otherwise reads drain the buffer first.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = AddrW,
  parameter int unsigned WB_DEPTH = WbDepthDef,
  parameter int unsigned READ_LAT = ReadLatDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_mw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              wb_full,
  output logic              wb_empty
);

  localparam int unsigned LatW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned WbCntW = $clog2(WB_DEPTH) + 1;

  mem_state_e          state_q, state_d;
  logic [LatW-1:0]     lat_cnt_q, lat_cnt_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [15:0]         cpu_rdata_q, cpu_rdata_d;

  logic                req_live, wr_req, rd_req, wr_stall;
  logic                wb_push, wb_pop, drain;
  wb_entry_t           wb_in, wb_head;
  logic [WbCntW-1:0]   wb_count;
`ifdef MEM_CTRL_WB_FWD_EN
  logic                fwd_hit;
  logic [7:0]          fwd_data;
`endif

  // The request still showing during the ready pulse belongs to the access just completed.
  assign req_live = cpu_req && !cpu_ready_q;
  assign wr_req   = req_live && cpu_mw;
  assign rd_req   = req_live && !cpu_mw;
  assign wr_stall = wr_req && wb_full;
  assign wb_push  = wr_req && !wb_full;
  assign wb_in    = '{addr: cpu_addr, data: cpu_wdata};

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;

  wr_buf #(
    .Depth(WB_DEPTH)
  ) u_wr_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (wb_push),
    .push_entry (wb_in),
    .pop        (wb_pop),
    .head       (wb_head),
    .count      (wb_count),
    .full       (wb_full),
    .empty      (wb_empty)
`ifdef MEM_CTRL_WB_FWD_EN
    ,
    .lookup_addr(cpu_addr),
    .lookup_hit (fwd_hit),
    .lookup_data(fwd_data)
`endif
  );

  // Next-state, RAM strobes and read capture. CPU traffic has priority over draining in IDLE,
  // except when a store is stalled on a full buffer, which needs a drain to make room.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    drain       = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    if (wb_push) cpu_ready_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
`ifdef MEM_CTRL_WB_FWD_EN
          if (fwd_hit) begin
            cpu_rdata_d = {8'h00, fwd_data};
            cpu_ready_d = 1'b1;
          end else begin
            state_d = StRdIssue;
          end
`else
          state_d = wb_empty ? StRdIssue : StDrain;
`endif
        end else if (!wb_empty && (!cpu_req || wr_stall)) begin
          drain = 1'b1;
        end
      end
      StDrain: begin
        if (wb_empty) begin
          state_d = StRdIssue;
        end else begin
          drain = 1'b1;
          if (wb_count == WbCntW'(1)) state_d = StRdIssue;
        end
      end
      StRdIssue: begin
        ram_en    = 1'b1;
        ram_addr  = cpu_addr;
        lat_cnt_d = '0;
        state_d   = StRdWait;
      end
      StRdWait: begin
        if (lat_cnt_q == LatW'(READ_LAT - 1)) begin
          cpu_rdata_d = ram_rdata;
          cpu_ready_d = 1'b1;
          state_d     = StIdle;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    wb_pop = drain;
    if (drain) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wb_head.addr;
      ram_wdata = {8'h00, wb_head.data};
    end
  end

  // FSM, latency counter and CPU-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: RAM model, program-order memory reference and directed + random traffic.
module tb_mem_ctrl;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned READ_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic              cpu_mw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [15:0]       cpu_rdata;
  logic              cpu_ready;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic              wb_full;
  logic              wb_empty;

  int checks   = 0;
  int failures = 0;

  mem_ctrl #(
    .ADDR_W  (ADDR_W),
    .WB_DEPTH(WB_DEPTH),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_mw   (cpu_mw),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .wb_full  (wb_full),
    .wb_empty (wb_empty)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [15:0] ram_q [256];
  bit          ram_wr [256];
  logic [15:0] rd_pipe [READ_LAT];
  logic [24:0] ram_log [$];   // {we, addr, wdata} per RAM access

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a ^ 8'h5C, ~a};
  endfunction

  function automatic logic [15:0] ram_read(input logic [7:0] a);
    return ram_wr[a] ? ram_q[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      ram_log.push_back({ram_we, ram_addr, ram_wdata});
      if (ram_we) begin
        ram_q[ram_addr]  <= ram_wdata;
        ram_wr[ram_addr] <= 1'b1;
      end
    end
    rd_pipe[0] <= (ram_en && !ram_we) ? ram_read(ram_addr) : 16'hxxxx;
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[READ_LAT-1];

  // ---------------- reference: memory as the CPU sees it ----------------
  logic [15:0] model_mem [256];
  logic [23:0] exp_wr [$];    // {addr, wdata} in program order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a store, wait for its ack, hold through the ack cycle, then release.
  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input int exp_lat,
                           input string tag);
    int n;
    cpu_req = 1'b1; cpu_mw = 1'b1; cpu_addr = a; cpu_wdata = d;
    n = 0;
    do begin tick(); n++; end while (!cpu_ready && n < 40);
    check({tag, "_ack"}, cpu_ready, 1);
    if (exp_lat != 0) check({tag, "_lat"}, n, exp_lat);
    model_mem[a] = {8'h00, d};
    exp_wr.push_back({a, 8'h00, d});
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input int exp_lat, input string tag);
    int n;
    cpu_req = 1'b1; cpu_mw = 1'b0; cpu_addr = a;
    n = 0;
    do begin tick(); n++; end while (!cpu_ready && n < 40);
    check({tag, "_ack"}, cpu_ready, 1);
    if (exp_lat != 0) check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, cpu_rdata, model_mem[a]);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    cpu_req = 1'b0;
    n = 0;
    while (!wb_empty && n < 40) begin tick(); n++; end
    check({tag, "_empty"}, wb_empty, 1);
  endtask

  // RAM writes must appear exactly in program order.
  task automatic check_log(input string tag);
    logic [24:0] op;
    logic [23:0] exp;
    while (ram_log.size() > 0) begin
      op = ram_log.pop_front();
      if (op[24]) begin
        exp = (exp_wr.size() > 0) ? exp_wr.pop_front() : 24'hxxxxxx;
        check({tag, "_wr_order"}, {8'h00, op[23:0]}, {8'h00, exp});
      end
    end
    check({tag, "_wr_left"}, exp_wr.size(), 0);
  endtask

  initial begin
    int n_wr, n_rd;
    logic [7:0] rd_a, a, d;
    rst = 1'b1; cpu_req = 1'b0; cpu_mw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));

    // Reset state
    tick(); tick();
    check("rst_ready", cpu_ready, 0);
    check("rst_rdata", cpu_rdata, 16'h0000);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wb_empty", wb_empty, 1);
    check("rst_wb_full", wb_full, 0);
    rst = 1'b0;

    // First read, empty buffer: minimum latency
    cpu_read(8'h10, READ_LAT + 2, "rd_beef");
    check("rd_beef_const", cpu_rdata, 16'hBEEF);

    // Posted writes back-to-back until full, then a stalled fifth
    for (int i = 0; i < 4; i++) cpu_write(8'(i + 1), 8'(8'hA1 + i), 1, "wr_post");
    check("wb_full_after4", wb_full, 1);
    cpu_write(8'h05, 8'hA5, 2, "wr_stall");
    wait_empty("post");
    check_log("post");
    for (int i = 0; i < 4; i++) check("ram_post", ram_read(8'(i + 1)), 16'h00A1 + 16'(i));

    check("rdata_hold_after_wr", cpu_rdata, 16'hBEEF);

`ifdef MEM_CTRL_WB_FWD_EN
    // Forwarding: youngest buffered store wins, no RAM access
    cpu_write(8'h30, 8'h11, 1, "fwd_w1");
    cpu_write(8'h30, 8'h22, 1, "fwd_w2");
    cpu_read(8'h30, 1, "fwd_hit");
    check("fwd_hit_const", cpu_rdata, 16'h0022);
    cpu_read(8'h31, READ_LAT + 2, "fwd_miss");
    n_wr = 0; n_rd = 0; rd_a = '0;
    foreach (ram_log[i]) begin
      if (ram_log[i][24]) n_wr++;
      else begin n_rd++; rd_a = ram_log[i][23:16]; end
    end
    check("fwd_ram_ops", {n_wr[7:0], n_rd[7:0], rd_a}, {8'd0, 8'd1, 8'h31});
    check("fwd_buf_kept", wb_empty, 0);
    wait_empty("fwd");
    check_log("fwd");
`else
    // Read-after-write: buffered store reaches RAM before the read
    cpu_write(8'h20, 8'h5A, 1, "raw_w");
    cpu_read(8'h20, 0, "raw_r");
    check("raw_const", cpu_rdata, 16'h005A);
    check("raw_log_len", ram_log.size(), 2);
    if (ram_log.size() == 2) begin
      check("raw_first_wr", {7'd0, ram_log[0]}, {7'd0, 1'b1, 8'h20, 16'h005A});
      check("raw_then_rd", {7'd0, ram_log[1][24:16]}, {7'd0, 1'b0, 8'h20});
    end
    check_log("raw");
`endif

    // Pointer wrap over 3 x depth stores with irregular gaps
    for (int i = 0; i < 3 * WB_DEPTH; i++) begin
      cpu_write(8'(8'h40 + i), 8'($urandom), 1, "wrap_w");
      idle(int'($urandom_range(0, 2)));
    end
    wait_empty("wrap");
    check_log("wrap");
    for (int i = 0; i < 3 * WB_DEPTH; i++)
      check("wrap_ram", ram_read(8'(8'h40 + i)), model_mem[8'h40 + i]);

    // Reset during RD_WAIT: read abandoned, no ack
    cpu_req = 1'b1; cpu_mw = 1'b0; cpu_addr = 8'h50;
    tick(); tick();
    rst = 1'b1; cpu_req = 1'b0;
    tick();
    check("rstrd_no_ready1", cpu_ready, 0);
    tick();
    check("rstrd_no_ready2", cpu_ready, 0);
    check("rstrd_empty", wb_empty, 1);
    check("rstrd_rdata", cpu_rdata, 16'h0000);
    rst = 1'b0;
    cpu_read(8'h50, READ_LAT + 2, "rstrd_next");
    check_log("rstrd");

    // Reset with stores still buffered: they are discarded
    cpu_write(8'h60, 8'h77, 1, "disc_w1");
    cpu_write(8'h61, 8'h88, 1, "disc_w2");
    cpu_req = 1'b1; cpu_mw = 1'b1; cpu_addr = 8'h62; cpu_wdata = 8'h00; rst = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    void'(exp_wr.pop_back());
    void'(exp_wr.pop_back());
    model_mem[8'h60] = init_val(8'h60);
    model_mem[8'h61] = init_val(8'h61);
    check("disc_empty", wb_empty, 1);
    idle(4);
    check("disc_no_ram", ram_log.size(), 0);
    cpu_read(8'h60, READ_LAT + 2, "disc_rd");

    // Random mixed traffic on a small address window
    for (int i = 0; i < 40; i++) begin
      a = 8'h70 + 8'($urandom_range(0, 7));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) cpu_write(a, d, 0, "rnd_w");
      else cpu_read(a, 0, "rnd_r");
      idle(int'($urandom_range(0, 2)));
    end
    wait_empty("rnd");
    check_log("rnd");
    for (int i = 0; i < 8; i++) check("rnd_ram", ram_read(8'(8'h70 + i)), model_mem[8'h70 + i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
